// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-serial little-endian load/store sequencer for an 8-bit data RAM port.
// Define MEM_ACCESS_MISALIGN_TRAP_EN to answer misaligned half/word requests with resp_err and no RAM access.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  PC,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_dout
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
    state_t state, state_nxt;
    logic we_q, uns_q, err_q, misalign;
    logic [1:0] size_q, lane;
    logic [2:0] cnt, n_bytes;
    logic [ADDR_WIDTH-1:0] addr_q, cur_addr;
    logic [31:0] wdata_q, rbuf, ext;
    assign n_bytes = size_q == 2'b00 ? 3'd1 : size_q == 2'b01 ? 3'd2 : 3'd4;
    assign cur_addr = addr_q + ADDR_WIDTH'(cnt);
    assign lane = 2'(cnt - 3'd1);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign misalign = req_size == 2'b00 ? 1'b0 : req_size == 2'b01 ? req_addr[0] : |req_addr[1:0];
`else
    assign misalign = 1'b0;
`endif
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = misalign ? DONE : req_we ? WRITE : READ;
            WRITE:   if (cnt == n_bytes - 3'd1) state_nxt = DONE;
            READ:    if (cnt == n_bytes) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge PC) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rbuf    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                err_q   <= misalign;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                cnt     <= '0;
                rbuf    <= '0;
            end else if (state == WRITE || state == READ) begin
                cnt <= cnt + 3'd1;
            end
            // RAM data trails the read enable by one cycle, so cycle c fills lane c-1
            if (state == READ && cnt != 3'd0) rbuf[{lane, 3'b000} +: 8] <= mem_dout;
        end
    end
    assign req_ready   = state == IDLE;
    assign mem_wr_en   = state == WRITE;
    assign mem_wr_addr = mem_wr_en ? cur_addr : '0;
    assign mem_din     = mem_wr_en ? DATA_WIDTH'(wdata_q[{cnt[1:0], 3'b000} +: 8]) : '0;
    assign mem_rd_en   = state == READ && cnt != n_bytes;
    assign mem_rd_addr = mem_rd_en ? cur_addr : '0;
    assign ext = size_q == 2'b00 ? {{24{~uns_q & rbuf[7]}}, rbuf[7:0]}
               : size_q == 2'b01 ? {{16{~uns_q & rbuf[15]}}, rbuf[15:0]} : rbuf;
    assign resp_valid = state == DONE;
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = resp_valid && !we_q && !err_q ? ext : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized load/store traffic against a transaction-level RAM model.
module tb_mem_access_unit;
    logic PC = 1'b0, rst = 1'b0, req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0] req_size = '0;
    logic [7:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic req_ready, resp_valid, resp_err, mem_wr_en, mem_rd_en;
    logic [31:0] resp_rdata;
    logic [7:0] mem_wr_addr, mem_din, mem_rd_addr, mem_dout;
    logic [7:0] ram [256];
    logic [7:0] ref_mem [256];
    logic preload = 1'b0;
    int total = 0, bad = 0;

    always #5 PC = ~PC;

    mem_access_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .PC(PC), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_din(mem_din),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_dout(mem_dout)
    );

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 73 + 19);
    endfunction

    always @(posedge PC) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ram[i] <= pat(i);
        end else if (mem_wr_en) begin
            ram[mem_wr_addr] <= mem_din;
        end
        if (mem_rd_en) mem_dout <= ram[mem_rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic misaligned(input logic [1:0] size, input logic [7:0] addr);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        return size == 2'd0 ? 1'b0 : size == 2'd1 ? addr[0] : addr[1:0] != 2'd0;
`else
        return 1'b0;
`endif
    endfunction

    // called #1 after the accept edge; returns the cycle index of the response
    task automatic wait_resp(input string tag, output int lat);
        lat = 1;
        while (!resp_valid && lat < 12) begin
            check({tag, " quiet"}, resp_rdata | {31'd0, resp_err}, 32'd0);
            @(posedge PC); #1;
            lat++;
        end
        check({tag, " valid"}, resp_valid, 1);
    endtask

    task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                       input logic [7:0] addr, input logic [31:0] wdata, input string tag);
        int n, lat, elat;
        longint v;
        logic err;
        logic [31:0] exp;
        n = size == 2'd0 ? 1 : size == 2'd1 ? 2 : 4;
        err = misaligned(size, addr);
        v = 0;
        for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(ref_mem[8'(addr + i)]);
        if (!uns && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        exp = (we || err) ? 32'd0 : 32'(v);
        elat = err ? 1 : we ? n + 1 : n + 2;
        @(negedge PC);
        check({tag, " ready"}, req_ready, 1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge PC); #1;
        req_valid = 1'b0;
        wait_resp(tag, lat);
        check({tag, " lat"}, lat, elat);
        check({tag, " rdata"}, resp_rdata, exp);
        check({tag, " err"}, resp_err, err);
        if (we && !err) for (int i = 0; i < n; i++) ref_mem[8'(addr + i)] = wdata[8 * i +: 8];
        @(posedge PC); #1;
        check({tag, " pulse"}, resp_valid, 0);
    endtask

    initial begin
        int lat;
        logic [7:0] sw_bytes [4];
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        preload = 1'b1;
        repeat (2) @(posedge PC);
        @(negedge PC);
        preload = 1'b0;
        check("rst ready", req_ready, 1);
        check("rst resp", {resp_valid, resp_err, resp_rdata[29:0]}, 32'd0);
        check("rst mem en", {mem_wr_en, mem_rd_en}, 0);
        check("rst mem bus", {mem_wr_addr, mem_din, mem_rd_addr}, 0);
        rst = 1'b1;

        txn(1, 2'd2, 0, 8'h10, 32'hDEADBEEF, "sw");
        sw_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int i = 0; i < 4; i++) check("sw ram", ram[8'h10 + i], sw_bytes[i]);
        txn(0, 2'd0, 0, 8'h13, 0, "lb");
        txn(0, 2'd0, 1, 8'h13, 0, "lbu");
        txn(0, 2'd2, 0, 8'h10, 0, "lw");
        txn(0, 2'd1, 0, 8'h12, 0, "lh12");
        txn(0, 2'd1, 1, 8'h12, 0, "lhu12");
        txn(0, 2'd1, 0, 8'h10, 0, "lh10");
        txn(1, 2'd1, 0, 8'hFF, 32'h00001234, "sh wrap");
        check("wrap ram ff", ram[8'hFF], ref_mem[8'hFF]);
        check("wrap ram 00", ram[8'h00], ref_mem[8'h00]);

        // reset lands on the edge ending the second WRITE cycle
        @(negedge PC);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 8'h20; req_wdata = 32'hCAFEF00D;
        @(posedge PC); #1;
        req_valid = 1'b0;
        check("abort wr0", mem_wr_en, 1);
        @(posedge PC);
        @(negedge PC);
        rst = 1'b0;
        @(posedge PC); #1;
        check("abort idle", req_ready, 1);
        @(negedge PC);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge PC); #1;
            check("abort no resp", resp_valid, 0);
        end
        ref_mem[8'h20] = 8'h0D;
        ref_mem[8'h21] = 8'hF0;
        for (int i = 0; i < 4; i++) check("abort ram", ram[8'h20 + i], ref_mem[8'h20 + i]);
        check("abort ready", req_ready, 1);

        // back-to-back with req_valid held: request fields change while busy
        @(negedge PC);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 8'h40; req_wdata = 32'h123456A5;
        @(posedge PC); #1;
        check("b2b busy1", req_ready, 0);
        @(negedge PC);
        req_we = 1'b0; req_unsigned = 1'b1; req_wdata = 32'h0;
        @(posedge PC); #1;
        check("b2b done", resp_valid, 1);
        check("b2b busy2", req_ready, 0);
        @(posedge PC); #1;
        check("b2b reaccept", req_ready, 1);
        check("b2b gap", resp_valid, 0);
        check("b2b sb ram", ram[8'h40], 8'hA5);
        @(posedge PC); #1;
        req_valid = 1'b0;
        check("b2b rd busy", req_ready, 0);
        wait_resp("b2b lbu", lat);
        check("b2b lbu lat", lat, 3);
        check("b2b lbu rdata", resp_rdata, 32'h000000A5);
        ref_mem[8'h40] = 8'hA5;
        @(posedge PC); #1;

        for (int k = 0; k < 300; k++) begin
            logic [7:0] a;
            a = ($urandom % 4 == 0) ? 8'(252 + $urandom % 8) : 8'($urandom);
            txn(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, "rnd");
        end
        for (int i = 0; i < 256; i++) check("final ram", ram[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
